// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
// Response codes, read FSM states and the byte-lane merge.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old,
    input logic [31:0] data,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register bank with per-register write pulses.
// Independent AW/W capture, single-beat commit, two-state read FSM.
module axi4_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [31:0]             S_AXI_WDATA,
  input  logic [3:0]              S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [31:0]             S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]  regs_o,
  output logic [NUM_REGS-1:0]     wr_pulse_o
);

  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LIMIT =
    ADDR_WIDTH'(NUM_REGS * 4);

  logic [31:0]           regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q;

  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic                  bvalid_q;
  resp_t                 bresp_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic                  wr_ok;
  logic [IW-1:0]         w_idx;

  rstate_t               r_state;
  rstate_t               r_next;
  logic [31:0]           rdata_q;
  resp_t                 rresp_q;
  logic                  ar_hs;
  logic                  ar_ok;
  logic [IW-1:0]         r_idx;

  assign S_AXI_AWREADY = !aw_held && !bvalid_q;
  assign S_AXI_WREADY  = !w_held && !bvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign commit = aw_held && w_held && !bvalid_q;
  assign wr_ok  = aw_addr < LIMIT;
  assign w_idx  = aw_addr[IW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? OKAY : SLVERR;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (commit && wr_ok) begin
        regs_q[w_idx] <=
          strb_merge(regs_q[w_idx], w_data, w_strb);
        if (|w_strb) pulse_q[w_idx] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign regs_o[32*k +: 32] = regs_q[k];
  end

  assign wr_pulse_o = pulse_q;

  assign ar_hs = S_AXI_ARVALID && (r_state == R_IDLE);
  assign ar_ok = S_AXI_ARADDR < LIMIT;
  assign r_idx = S_AXI_ARADDR[IW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = 1'b1;
        if (S_AXI_ARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_next = R_IDLE;
      end
    endcase
  end

  // Sampled before any same-edge commit lands, so reads see the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else if (ar_hs) begin
      rdata_q <= ar_ok ? regs_q[r_idx] : '0;
      rresp_q <= ar_ok ? OKAY : SLVERR;
    end
  end

  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Randomized bench for axi4_lite_slave_regs.
// Reference model is a plain word array updated per transaction.
module tb_axi4_lite_slave_regs;

  localparam int AW = 32;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [NR*32-1:0] regs_o;
  logic [NR-1:0] wr_pulse_o;

  always #5 clk = ~clk;

  axi4_lite_slave_regs #(.ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NR];

  task automatic chk(input string tag,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] exp_regs();
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'(NR * 4);
  endfunction

  task automatic model_write(input logic [31:0] a,
                             input logic [31:0] d,
                             input logic [3:0] s,
                             output logic [1:0] resp,
                             output logic [NR-1:0] pulse);
    int k;
    pulse = '0;
    resp  = 2'b10;
    if (in_rng(a)) begin
      k = int'(a >> 2);
      resp = 2'b00;
      for (int i = 0; i < 4; i++)
        if (s[i]) model[k][8*i +: 8] = d[8*i +: 8];
      if (s != 4'h0) pulse[k] = 1'b1;
    end
  endtask

  task automatic axi_write(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s,
                           input int da, input int dw,
                           input int bd);
    bit aw_done = 0;
    bit w_done = 0;
    bit hs_aw, hs_w;
    int t = 0;
    int n = 0;
    logic [1:0] er;
    logic [NR-1:0] ep;
    while (!(aw_done && w_done) && t < 100) begin
      @(negedge clk);
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = !aw_done && t >= da;
      wvalid  = !w_done && t >= dw;
      if (w_done) chk("wready_held", wready, 0);
      if (aw_done) chk("awready_held", awready, 0);
      if (w_done && !aw_done) chk("awready_w_held", awready, 1);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk);
      if (hs_aw) aw_done = 1;
      if (hs_w) w_done = 1;
      t++;
    end
    if (!(aw_done && w_done)) chk("wr_accept_timeout", 0, 1);
    model_write(a, d, s, er, ep);
    do begin
      @(negedge clk);
      awvalid = 0;
      wvalid  = 0;
      n++;
    end while (!bvalid && n < 20);
    chk("b_latency", n, 2);
    chk("bresp", bresp, er);
    chk("wr_pulse", wr_pulse_o, ep);
    chk("regs", regs_o, exp_regs());
    for (int i = 0; i < bd; i++) begin
      awaddr  = 32'hC;
      awvalid = 1;
      @(negedge clk);
      chk("b_hold", {bvalid, bresp, awready, wready},
          {1'b1, er, 2'b00});
      chk("pulse_once", wr_pulse_o, 0);
    end
    bready = 1;
    @(posedge clk);
    @(negedge clk);
    bready  = 0;
    awvalid = 0;
    chk("b_done", {bvalid, awready, wready}, 3'b011);
    chk("pulse_clear", wr_pulse_o, 0);
    chk("regs_after", regs_o, exp_regs());
  endtask

  task automatic axi_read(input logic [31:0] a, input int rd);
    logic [31:0] ed;
    logic [1:0] er;
    @(negedge clk);
    araddr  = a;
    arvalid = 1;
    chk("arready_idle", arready, 1);
    ed = in_rng(a) ? model[int'(a >> 2)] : 32'h0;
    er = in_rng(a) ? 2'b00 : 2'b10;
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    chk("rvalid_lat", rvalid, 1);
    chk("rdata", rdata, ed);
    chk("rresp", rresp, er);
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      chk("r_hold", {rvalid, arready, rdata, rresp},
          {1'b1, 1'b0, ed, er});
    end
    rready = 1;
    @(posedge clk);
    @(negedge clk);
    rready = 0;
    chk("r_done", {rvalid, arready}, 2'b01);
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 32'h20 + $urandom_range(0, 31);
    if (r == 1) return $urandom | 32'h8000_0000;
    return $urandom_range(0, NR * 4 - 1);
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk(tag, {awready, wready, arready, bvalid, rvalid,
              bresp, rresp, wr_pulse_o},
        {3'b111, 2'b00, 4'h0, 8'h00});
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_regs"}, regs_o, 0);
  endtask

  initial begin
    rst = 1;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0;
    wvalid = 0; bready = 0; araddr = 0; arvalid = 0;
    rready = 0;
    for (int k = 0; k < NR; k++) model[k] = 0;
    #12;
    chk_reset_outs("reset");
    @(negedge clk);
    rst = 0;

    axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_write(32'h8, 32'hAAAAAAAA, 4'hF, 1, 0, 0);
    axi_write(32'h8, 32'h11223344, 4'h3, 3, 0, 4);
    chk("reg2_merge", regs_o[95:64], 32'hAAAA3344);
    axi_write(32'h20, 32'h1, 4'hF, 0, 0, 1);
    axi_write(32'h1000_0004, 32'h5, 4'hF, 2, 1, 0);
    axi_write(32'hC, 32'hFFFF_FFFF, 4'h0, 0, 2, 0);
    axi_read(32'h4, 5);
    axi_read(32'h20, 0);
    axi_read(32'hA, 1);

    axi_write(32'h4, 32'h5, 4'hF, 0, 0, 0);
    @(negedge clk);
    awaddr = 32'h4; wdata = 32'h7; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    araddr = 32'h4; arvalid = 1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 0;
    chk("same_edge_rdata", rdata, 32'h5);
    chk("same_edge_bvalid", bvalid, 1);
    model[1] = 32'h7;
    chk("same_edge_regs", regs_o, exp_regs());
    bready = 1; rready = 1;
    @(posedge clk);
    @(negedge clk);
    bready = 0; rready = 0;
    axi_read(32'h4, 0);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 0)
        axi_write(rnd_addr(), $urandom,
                  4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
      else
        axi_read(rnd_addr(), int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    wdata = 32'hBAD0BAD0; wstrb = 4'hF; wvalid = 1;
    araddr = 32'h8; arvalid = 1;
    @(posedge clk);
    @(negedge clk);
    wvalid = 0; arvalid = 0;
    chk("pre_rst_state", {wready, rvalid}, 2'b01);
    rst = 1;
    #1;
    chk_reset_outs("mid_reset");
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < NR; k++) model[k] = 0;
    axi_write(32'h8, 32'h0000_1234, 4'hF, 0, 3, 0);
    axi_read(32'h8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
